// File: rtl/fault_monitor_if.sv
// Fault bus plus pulse report bundle between a fault source and fault_monitor.
// master drives the fault bus and observes reports; slave is the monitor side.
interface fault_monitor_if #(
  parameter int N             = 256,
  parameter int counter_width = 32,
  parameter int address_width = 8
);
  logic [N-1:0]             FI_in;
  logic                     rpt_valid;
  logic [address_width-1:0] rpt_addr;
  logic [counter_width-1:0] rpt_len;
  logic [counter_width-1:0] rpt_gap;
  logic [3:0]               rpt_err;
  logic [counter_width-1:0] pulse_cnt;
  logic [counter_width-1:0] err_cnt;
  logic                     sticky_err;

  modport master (
    output FI_in,
    input  rpt_valid, rpt_addr, rpt_len, rpt_gap, rpt_err,
    input  pulse_cnt, err_cnt, sticky_err
  );

  modport slave (
    input  FI_in,
    output rpt_valid, rpt_addr, rpt_len, rpt_gap, rpt_err,
    output pulse_cnt, err_cnt, sticky_err
  );
endinterface

// File: rtl/fault_monitor.sv
// Receive-side checker for a one-hot fault bus: measures each pulse's line,
// width and preceding gap, flags deviations from the injector schedule.
module fault_monitor #(
  parameter int N             = 256,
  parameter int DELAY_CYCLES  = 100,
  parameter int PULSE_LENGTH  = 2,
  parameter int counter_width = 32,
  parameter int address_width = 8
) (
  input  logic            clk,
  input  logic            rst,
  fault_monitor_if.slave  mon
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [N-1:0] BUS_ONE = N'(1);

  state_t                   state;
  logic [counter_width-1:0] gap_cnt;
  logic [address_width-1:0] cur_addr;
  logic [counter_width-1:0] cur_len;
  logic [counter_width-1:0] cur_gap;
  logic                     cur_multi;
  logic                     first_flag;
  logic [address_width-1:0] exp_addr;

  logic [address_width-1:0] hit_addr;
  logic                     hit_found;
  logic                     any_hit;
  logic                     multi_hit;
  logic                     do_rpt;
  logic [3:0]               cur_err;

  function automatic logic [counter_width-1:0] sat_inc(input logic [counter_width-1:0] v);
    return (&v) ? v : v + counter_width'(1);
  endfunction

  function automatic logic [address_width-1:0] next_addr(input logic [address_width-1:0] a);
    return (a == address_width'(N - 1)) ? '0 : a + address_width'(1);
  endfunction

  // Decode: lowest set line wins; multi-hot is any second bit set
  always_comb begin
    hit_addr  = '0;
    hit_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mon.FI_in[i] && !hit_found) begin
        hit_addr  = address_width'(i);
        hit_found = 1'b1;
      end
    end
    any_hit   = |mon.FI_in;
    multi_hit = (mon.FI_in & (mon.FI_in - BUS_ONE)) != '0;
  end

  // A pulse ends when the bus drops or a different line takes over
  always_comb begin
    do_rpt  = (state == ACTIVE) && (!any_hit || (hit_addr != cur_addr));
    cur_err = {cur_addr != exp_addr,
               !first_flag && (cur_gap != counter_width'(DELAY_CYCLES)),
               cur_len != counter_width'(PULSE_LENGTH),
               cur_multi};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      cur_addr       <= '0;
      cur_len        <= '0;
      cur_gap        <= '0;
      cur_multi      <= 1'b0;
      first_flag     <= 1'b1;
      exp_addr       <= '0;
      mon.rpt_valid  <= 1'b0;
      mon.rpt_addr   <= '0;
      mon.rpt_len    <= '0;
      mon.rpt_gap    <= '0;
      mon.rpt_err    <= '0;
      mon.pulse_cnt  <= '0;
      mon.err_cnt    <= '0;
      mon.sticky_err <= 1'b0;
    end else begin
      mon.rpt_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!any_hit) begin
            gap_cnt <= sat_inc(gap_cnt);
          end else begin
            state     <= ACTIVE;
            cur_addr  <= hit_addr;
            cur_len   <= counter_width'(1);
            cur_multi <= multi_hit;
            cur_gap   <= gap_cnt;
            gap_cnt   <= '0;
          end
        end
        ACTIVE: begin
          if (!any_hit) begin
            state   <= IDLE;
            gap_cnt <= counter_width'(1);
          end else if (hit_addr == cur_addr) begin
            cur_len   <= sat_inc(cur_len);
            cur_multi <= cur_multi | multi_hit;
          end else begin
            // Back-to-back line change: new pulse opens with zero gap
            cur_addr  <= hit_addr;
            cur_len   <= counter_width'(1);
            cur_multi <= multi_hit;
            cur_gap   <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // Report stage: outputs register one cycle after the terminating sample
      if (do_rpt) begin
        mon.rpt_valid <= 1'b1;
        mon.rpt_addr  <= cur_addr;
        mon.rpt_len   <= cur_len;
        mon.rpt_gap   <= cur_gap;
        mon.rpt_err   <= cur_err;
        mon.pulse_cnt <= mon.pulse_cnt + counter_width'(1);
        if (cur_err != 4'b0000) begin
          mon.err_cnt    <= mon.err_cnt + counter_width'(1);
          mon.sticky_err <= 1'b1;
        end
        exp_addr   <= next_addr(cur_addr);
        first_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fault_monitor.sv
// Scoreboard bench for fault_monitor: pulse tasks push expected reports,
// a negedge monitor pops and compares them when rpt_valid fires.
module tb_fault_monitor;
  localparam int N     = 256;
  localparam int DELAY = 100;
  localparam int PULSE = 2;
  localparam int CW    = 32;
  localparam int AW    = 8;

  typedef struct {
    int       addr;
    int       len;
    int       gap;
    logic [3:0] err;
    int       pcnt;
    int       ecnt;
    bit       sticky;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q[$];
  int   m_exp    = 0;
  bit   m_first  = 1'b1;
  int   m_pcnt   = 0;
  int   m_ecnt   = 0;
  bit   m_sticky = 1'b0;
  int   idle_run = 0;

  fault_monitor_if #(.N(N), .counter_width(CW), .address_width(AW)) fm_if ();

  fault_monitor #(
    .N(N), .DELAY_CYCLES(DELAY), .PULSE_LENGTH(PULSE),
    .counter_width(CW), .address_width(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (fm_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_exp    = 0;
    m_first  = 1'b1;
    m_pcnt   = 0;
    m_ecnt   = 0;
    m_sticky = 1'b0;
    idle_run = 0;
  endtask

  task automatic push_exp(input int addr, input int len, input int gap, input bit multi);
    exp_t e;
    e.addr = addr;
    e.len  = len;
    e.gap  = gap;
    e.err  = {addr != m_exp, !m_first && (gap != DELAY), len != PULSE, multi};
    m_exp   = (addr + 1) % N;
    m_first = 1'b0;
    m_pcnt++;
    if (e.err != 4'b0000) begin
      m_ecnt++;
      m_sticky = 1'b1;
    end
    e.pcnt   = m_pcnt;
    e.ecnt   = m_ecnt;
    e.sticky = m_sticky;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      fm_if.FI_in = '0;
      idle_run++;
      @(negedge clk);
    end
  endtask

  // extra holds additional bits strictly above addr for multi-hot pulses
  task automatic pulse(input int addr, input logic [N-1:0] extra, input int len);
    logic [N-1:0] v;
    int gap;
    v       = extra;
    v[addr] = 1'b1;
    gap      = idle_run;
    idle_run = 0;
    fm_if.FI_in = v;
    repeat (len) @(negedge clk);
    push_exp(addr, len, gap, extra != '0);
  endtask

  always @(negedge clk) begin
    if (fm_if.rpt_valid) begin
      if (q.size() == 0) begin
        check("unexpected_rpt", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rpt_addr",   fm_if.rpt_addr,   e.addr);
        check("rpt_len",    fm_if.rpt_len,    e.len);
        check("rpt_gap",    fm_if.rpt_gap,    e.gap);
        check("rpt_err",    fm_if.rpt_err,    e.err);
        check("pulse_cnt",  fm_if.pulse_cnt,  e.pcnt);
        check("err_cnt",    fm_if.err_cnt,    e.ecnt);
        check("sticky_err", fm_if.sticky_err, e.sticky);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    fm_if.FI_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid",  fm_if.rpt_valid,  0);
    check("rst_addr",   fm_if.rpt_addr,   0);
    check("rst_len",    fm_if.rpt_len,    0);
    check("rst_gap",    fm_if.rpt_gap,    0);
    check("rst_err",    fm_if.rpt_err,    0);
    check("rst_pcnt",   fm_if.pulse_cnt,  0);
    check("rst_ecnt",   fm_if.err_cnt,    0);
    check("rst_sticky", fm_if.sticky_err, 0);
    rst = 1'b0;
    model_reset();

    // Nominal: first gap suppressed, second gap exactly DELAY
    idle(5);
    pulse(0, '0, PULSE); idle(DELAY);
    pulse(1, '0, PULSE); idle(DELAY);
    check("nom_pcnt",   fm_if.pulse_cnt,  2);
    check("nom_ecnt",   fm_if.err_cnt,    0);
    check("nom_sticky", fm_if.sticky_err, 0);

    // Walk every line, then wrap back to line 0
    for (int a = 2; a < N; a++) begin
      pulse(a, '0, PULSE); idle(DELAY);
    end
    pulse(0, '0, PULSE); idle(DELAY);
    check("wrap_pcnt", fm_if.pulse_cnt, N + 1);
    check("wrap_ecnt", fm_if.err_cnt,   0);

    // Out-of-order line, then length and gap faults
    pulse(5, '0, PULSE); idle(DELAY - 1);
    check("seq_sticky", fm_if.sticky_err, 1);
    pulse(6, '0, 3); idle(DELAY);

    // Multi-hot bits 2 and 3
    pulse(2, N'(8), PULSE); idle(DELAY);

    // Overlap: line 4 hands straight over to line 5
    pulse(4, '0, 1);
    pulse(5, '0, PULSE); idle(DELAY);
    check("ovl_ecnt", fm_if.err_cnt, m_ecnt);

    // Reset in the middle of a pulse discards it
    fm_if.FI_in = N'(8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fm_if.FI_in = '0;
    check("mid_rst_valid",  fm_if.rpt_valid,  0);
    check("mid_rst_pcnt",   fm_if.pulse_cnt,  0);
    check("mid_rst_ecnt",   fm_if.err_cnt,    0);
    check("mid_rst_sticky", fm_if.sticky_err, 0);
    model_reset();
    idle(10);
    pulse(0, '0, PULSE); idle(10);
    pulse(1, '0, PULSE); idle(20);

    waited = 0;
    while (q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("drain", q.size(), 0);
    check("end_pcnt", fm_if.pulse_cnt, 2);
    check("end_ecnt", fm_if.err_cnt,   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
